// File: rtl/mips32_dmem_responder.sv
// mips32_dmem_responder: valid/ready data-memory responder with programmable wait states
module mips32_dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    state_t         state;
    logic [3:0]     cnt;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    mem [DEPTH];
    logic           do_acc;
    logic           in_range;
    logic [AW-1:0]  idx;
    assign req_ready = rst_n && (state == ST_IDLE);
    assign do_acc    = (state == ST_WAIT) && (cnt == 4'd0);
    assign in_range  = addr_q < 32'(DEPTH);
    assign idx       = addr_q[AW-1:0];
    // Request latch, wait countdown, access on entry to RESP, response hold until handshake
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else
            case (state)
                ST_IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    cnt     <= 4'(WAIT_CYCLES);
                    state   <= ST_WAIT;
                end
                ST_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= !in_range;
                    rsp_rdata <= (in_range && !we_q) ? mem[idx] : '0;
                end
                ST_RESP: if (rsp_ready) begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
    // Array write happens on the same edge the response is produced; never reset
    always_ff @(posedge clk)
        if (do_acc && we_q && in_range) mem[idx] <= wdata_q;
endmodule

// File: tb/tb_mips32_dmem_responder.sv
// tb_mips32_dmem_responder: four responders (waits 2,0,5,15) checked against a word-map model
module tb_mips32_dmem_responder;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic              rst_n = 1'b0;
    logic [3:0]        req_valid = '0;
    logic [3:0]        req_we = '0;
    logic [3:0][31:0]  req_addr = '0;
    logic [3:0][31:0]  req_wdata = '0;
    logic [3:0]        rsp_ready = '1;
    wire  [3:0]        req_ready;
    wire  [3:0]        rsp_valid;
    wire  [3:0]        rsp_err;
    wire  [3:0][31:0]  rsp_rdata;
    int wc[4] = '{2, 0, 5, 15};
    int vecs = 0;
    int errs = 0;
    logic [31:0] mdl [longint];
    for (genvar g = 0; g < 4; g++) begin : u
        mips32_dmem_responder #(
            .DEPTH(1024),
            .WAIT_CYCLES(g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 5 : 15)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we(req_we[g]),
            .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err(rsp_err[g])
        );
    end
    function automatic logic [32:0] model(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        longint key;
        key = {k, addr};
        if (addr >= 32'd1024) return {1'b1, 32'h0};
        if (we) begin
            mdl[key] = wdata;
            return 33'h0;
        end
        return {1'b0, mdl.exists(key) ? mdl[key] : 32'hx};
    endfunction
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit hs,
                       output int lat, output logic [31:0] rd, output logic er, output logic rdy);
        req_we[k] = we;
        req_addr[k] = addr;
        req_wdata[k] = wdata;
        req_valid[k] = 1'b1;
        step;
        req_valid[k] = 1'b0;
        req_we[k] = 1'($urandom);
        req_addr[k] = $urandom;
        req_wdata[k] = $urandom;
        lat = 0;
        while (!rsp_valid[k] && lat < 40) begin
            step;
            lat++;
        end
        rd = rsp_rdata[k];
        er = rsp_err[k];
        rdy = 1'bx;
        if (hs) begin
            rsp_ready[k] = 1'b1;
            step;
            rdy = req_ready[k] && !rsp_valid[k];
        end
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        step;
        step;
        vecs++;
        if (req_ready !== 4'h0 || rsp_valid !== 4'h0 || rsp_err !== 4'h0 || rsp_rdata !== '0) begin
            errs++;
            $display("FAIL reset_values: ready=%b valid=%b err=%b rdata=%h, want all zero", req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst_n = 1'b1;
        step;
        vecs++;
        if (req_ready !== 4'hf || rsp_valid !== 4'h0) begin
            errs++;
            $display("FAIL reset_release: ready=%b valid=%b, want ready=1111 valid=0000", req_ready, rsp_valid);
        end
    endtask
    task automatic test_store_load;
        op_t ops[6] = '{'{1'b1, 32'd5, 32'hDEADBEEF}, '{1'b0, 32'd5, 32'h0}, '{1'b1, 32'd0, 32'hCAFEF00D},
                        '{1'b1, 32'd1023, 32'h0BADF00D}, '{1'b0, 32'd0, 32'h0}, '{1'b0, 32'd1023, 32'h0}};
        logic [32:0] e;
        int lat;
        logic [31:0] rd;
        logic er, rdy;
        foreach (ops[i]) begin
            e = model(0, ops[i].we, ops[i].addr, ops[i].data);
            txn(0, ops[i].we, ops[i].addr, ops[i].data, 1'b1, lat, rd, er, rdy);
            vecs++;
            if (lat != wc[0] + 1 || {er, rd} !== e || rdy !== 1'b1) begin
                errs++;
                $display("FAIL store_load[%0d]: lat=%0d err=%b rdata=%h ready=%b, want lat=%0d err=%b rdata=%h ready=1",
                         i, lat, er, rd, rdy, wc[0] + 1, e[32], e[31:0]);
            end
        end
    endtask
    task automatic test_zero_wait;
        op_t ops[5] = '{'{1'b1, 32'd1023, 32'h12345678}, '{1'b0, 32'd1023, 32'h0}, '{1'b1, 32'd3, 32'h0000_0003},
                        '{1'b0, 32'd3, 32'h0}, '{1'b0, 32'd1023, 32'h0}};
        logic [32:0] e;
        int lat;
        logic [31:0] rd;
        logic er, rdy;
        foreach (ops[i]) begin
            e = model(1, ops[i].we, ops[i].addr, ops[i].data);
            txn(1, ops[i].we, ops[i].addr, ops[i].data, 1'b1, lat, rd, er, rdy);
            vecs++;
            if (lat != 1 || {er, rd} !== e || rdy !== 1'b1) begin
                errs++;
                $display("FAIL zero_wait[%0d]: lat=%0d err=%b rdata=%h ready=%b, want lat=1 err=%b rdata=%h ready=1",
                         i, lat, er, rd, rdy, e[32], e[31:0]);
            end
        end
    endtask
    task automatic test_out_of_range;
        op_t ops[6] = '{'{1'b1, 32'd1024, 32'hFFFFFFFF}, '{1'b0, 32'h80000000, 32'h0}, '{1'b1, 32'hFFFFFFFF, 32'h1},
                        '{1'b0, 32'd0, 32'h0}, '{1'b0, 32'd1023, 32'h0}, '{1'b0, 32'd5, 32'h0}};
        logic [32:0] e;
        int lat;
        logic [31:0] rd;
        logic er, rdy;
        foreach (ops[i]) begin
            e = model(0, ops[i].we, ops[i].addr, ops[i].data);
            txn(0, ops[i].we, ops[i].addr, ops[i].data, 1'b1, lat, rd, er, rdy);
            vecs++;
            if (lat != wc[0] + 1 || {er, rd} !== e || rdy !== 1'b1) begin
                errs++;
                $display("FAIL out_of_range[%0d] addr=%h: lat=%0d err=%b rdata=%h ready=%b, want lat=%0d err=%b rdata=%h ready=1",
                         i, ops[i].addr, lat, er, rd, rdy, wc[0] + 1, e[32], e[31:0]);
            end
        end
    endtask
    task automatic test_backpressure;
        logic [32:0] e;
        int lat;
        logic [31:0] rd;
        logic er, rdy;
        e = model(0, 1'b0, 32'd5, 32'h0);
        rsp_ready[0] = 1'b0;
        txn(0, 1'b0, 32'd5, 32'h0, 1'b0, lat, rd, er, rdy);
        vecs++;
        if (lat != wc[0] + 1 || {er, rd} !== e) begin
            errs++;
            $display("FAIL backpressure_load: lat=%0d err=%b rdata=%h, want lat=%0d err=%b rdata=%h", lat, er, rd, wc[0] + 1, e[32], e[31:0]);
        end
        for (int i = 0; i < 10; i++) begin
            req_valid[0] = 1'b1;
            req_we[0] = 1'b1;
            req_addr[0] = 32'd5;
            req_wdata[0] = $urandom;
            step;
            vecs++;
            if (rsp_valid[0] !== 1'b1 || {rsp_err[0], rsp_rdata[0]} !== e || req_ready[0] !== 1'b0) begin
                errs++;
                $display("FAIL backpressure_hold[%0d]: valid=%b err=%b rdata=%h ready=%b, want valid=1 err=%b rdata=%h ready=0",
                         i, rsp_valid[0], rsp_err[0], rsp_rdata[0], req_ready[0], e[32], e[31:0]);
            end
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        step;
        vecs++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errs++;
            $display("FAIL backpressure_release: valid=%b ready=%b, want valid=0 ready=1", rsp_valid[0], req_ready[0]);
        end
        e = model(0, 1'b0, 32'd5, 32'h0);
        txn(0, 1'b0, 32'd5, 32'h0, 1'b1, lat, rd, er, rdy);
        vecs++;
        if (lat != wc[0] + 1 || {er, rd} !== e || rdy !== 1'b1) begin
            errs++;
            $display("FAIL backpressure_ignored_store: lat=%0d err=%b rdata=%h ready=%b, want rdata=%h", lat, er, rd, rdy, e[31:0]);
        end
    endtask
    task automatic test_reset_mid_wait;
        op_t ops[3] = '{'{1'b1, 32'd7, 32'h0}, '{1'b0, 32'd7, 32'h0}, '{1'b0, 32'd9, 32'h0}};
        int kk[3] = '{2, 2, 0};
        logic [32:0] e;
        int lat;
        logic [31:0] rd;
        logic er, rdy;
        e = model(2, 1'b1, 32'd7, 32'h11111111);
        txn(2, 1'b1, 32'd7, 32'h11111111, 1'b1, lat, rd, er, rdy);
        vecs++;
        if (lat != wc[2] + 1 || {er, rd} !== e || rdy !== 1'b1) begin
            errs++;
            $display("FAIL midwait_preload: lat=%0d err=%b rdata=%h ready=%b, want lat=%0d", lat, er, rd, rdy, wc[2] + 1);
        end
        e = model(0, 1'b1, 32'd9, 32'h5A5A5A5A);
        rsp_ready[0] = 1'b0;
        txn(0, 1'b1, 32'd9, 32'h5A5A5A5A, 1'b0, lat, rd, er, rdy);
        req_we[2] = 1'b1;
        req_addr[2] = 32'd7;
        req_wdata[2] = 32'hA5A5A5A5;
        req_valid[2] = 1'b1;
        step;
        req_valid[2] = 1'b0;
        step;
        step;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (rsp_valid !== 4'h0 || req_ready !== 4'h0) begin
            errs++;
            $display("FAIL midwait_reset: valid=%b ready=%b, want valid=0000 ready=0000", rsp_valid, req_ready);
        end
        step;
        step;
        rst_n = 1'b1;
        rsp_ready[0] = 1'b1;
        step;
        foreach (ops[i]) begin
            if (i == 0) continue;
            e = model(kk[i], ops[i].we, ops[i].addr, ops[i].data);
            txn(kk[i], ops[i].we, ops[i].addr, ops[i].data, 1'b1, lat, rd, er, rdy);
            vecs++;
            if (lat != wc[kk[i]] + 1 || {er, rd} !== e || rdy !== 1'b1) begin
                errs++;
                $display("FAIL midwait_after[%0d] addr=%0d: lat=%0d err=%b rdata=%h ready=%b, want err=%b rdata=%h",
                         i, ops[i].addr, lat, er, rd, rdy, e[32], e[31:0]);
            end
        end
    endtask
    task automatic test_max_wait;
        op_t ops[3] = '{'{1'b1, 32'd100, 32'h600DCAFE}, '{1'b0, 32'd100, 32'h0}, '{1'b0, 32'd2000, 32'h0}};
        logic [32:0] e;
        int lat;
        logic [31:0] rd;
        logic er, rdy;
        foreach (ops[i]) begin
            e = model(3, ops[i].we, ops[i].addr, ops[i].data);
            txn(3, ops[i].we, ops[i].addr, ops[i].data, 1'b1, lat, rd, er, rdy);
            vecs++;
            if (lat != 16 || {er, rd} !== e || rdy !== 1'b1) begin
                errs++;
                $display("FAIL max_wait[%0d]: lat=%0d err=%b rdata=%h ready=%b, want lat=16 err=%b rdata=%h ready=1",
                         i, lat, er, rd, rdy, e[32], e[31:0]);
            end
        end
    endtask
    task automatic test_random;
        logic [32:0] e;
        int lat, n;
        logic [31:0] rd, a, d;
        logic er, rdy, we;
        logic [32:0] held;
        logic hv;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] pool[$];
            for (int i = 0; i < 25; i++) begin
                we = (pool.size() == 0) || ($urandom_range(0, 9) < 4);
                if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
                else if (we) a = $urandom_range(0, 1023);
                else a = pool[$urandom_range(0, pool.size() - 1)];
                d = $urandom;
                if (we && a < 32'd1024) pool.push_back(a);
                e = model(k, we, a, d);
                n = $urandom_range(0, 3);
                rsp_ready[k] = 1'b0;
                txn(k, we, a, d, 1'b0, lat, rd, er, rdy);
                repeat (n) step;
                held = {rsp_err[k], rsp_rdata[k]};
                hv = rsp_valid[k];
                rsp_ready[k] = 1'b1;
                step;
                rdy = req_ready[k] && !rsp_valid[k];
                vecs++;
                if (lat != wc[k] + 1 || {er, rd} !== e || held !== e || hv !== 1'b1 || rdy !== 1'b1) begin
                    errs++;
                    $display("FAIL random k=%0d #%0d we=%b addr=%h: lat=%0d err=%b rdata=%h held=%h valid=%b ready=%b, want lat=%0d err=%b rdata=%h",
                             k, i, we, a, lat, er, rd, held, hv, rdy, wc[k] + 1, e[32], e[31:0]);
                end
            end
        end
    endtask
    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        test_reset;
        test_store_load;
        test_zero_wait;
        test_out_of_range;
        test_backpressure;
        test_reset_mid_wait;
        test_max_wait;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
